// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types for the systolic array load sequencer
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    KIND_W,
    KIND_I,
    KIND_P
  } beat_kind_t;

  localparam int DEFAULT_ARRAY_DIM = 4;
  localparam int ROW_W = $clog2(DEFAULT_ARRAY_DIM);

endpackage

// File: rtl/systolic_array_loader.sv
// rtl/systolic_array_loader.sv - fetches weight/input/partial rows from scratchpad and issues them to the array control unit
module systolic_array_loader
  import systolic_pkg::*;
#(
  parameter int ARRAY_DIM = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             w_base,
  input  logic [ADDR_W-1:0]             i_base,
  input  logic [ADDR_W-1:0]             p_base,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ready,
  input  logic [ARRAY_DIM*DATA_W-1:0]   mem_rdata,
  input  logic                          fifo_has_space,
  output logic                          weight_en,
  output logic                          input_en,
  output logic                          partial_en,
  output logic [$clog2(ARRAY_DIM)-1:0]  row_in_en,
  output logic [$clog2(ARRAY_DIM)-1:0]  row_ps_en,
  output logic [ARRAY_DIM*DATA_W-1:0]   array_bus
);

  localparam int ROW_BITS = $clog2(ARRAY_DIM);
  localparam int BUS_W    = ARRAY_DIM * DATA_W;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ARRAY_DIM - 1);

  loader_state_t       state, state_n;
  beat_kind_t          kind, kind_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic [ADDR_W-1:0]   w_base_q, i_base_q, p_base_q;
  logic [ADDR_W-1:0]   next_base;
  logic [BUS_W-1:0]    hold;
  logic                beat_fire;

  // Next-state sequencing over W0..W(N-1), I0,P0,...,I(N-1),P(N-1), plus decoded beat outputs
  always_comb begin
    state_n    = state;
    kind_n     = kind;
    row_n      = row;
    beat_fire  = 1'b0;
    next_base  = w_base_q;
    weight_en  = 1'b0;
    input_en   = 1'b0;
    partial_en = 1'b0;
    row_in_en  = '0;
    row_ps_en  = '0;
    array_bus  = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          kind_n  = KIND_W;
          row_n   = '0;
        end
      end
      FETCH: begin
        if (mem_ready) state_n = ISSUE;
      end
      ISSUE: begin
        // Weight beats go out unconditionally; input/partial wait for FIFO space.
        beat_fire = (kind == KIND_W) || fifo_has_space;
        if (beat_fire) begin
          state_n = FETCH;
          case (kind)
            KIND_W: begin
              if (row == LAST_ROW) begin
                kind_n = KIND_I;
                row_n  = '0;
              end else begin
                row_n = row + ROW_BITS'(1);
              end
            end
            KIND_I: kind_n = KIND_P;
            default: begin
              if (row == LAST_ROW) begin
                state_n = DONE;
              end else begin
                kind_n = KIND_I;
                row_n  = row + ROW_BITS'(1);
              end
            end
          endcase
        end
        weight_en  = (kind == KIND_W);
        input_en   = (kind == KIND_I) && fifo_has_space;
        partial_en = (kind == KIND_P) && fifo_has_space;
        if (weight_en || input_en) row_in_en = row;
        if (partial_en)            row_ps_en = row;
        if (beat_fire)             array_bus = hold;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // The bases are not latched yet on the start cycle, so the first fetch uses the port value.
    if (state == IDLE) begin
      next_base = w_base;
    end else begin
      case (kind_n)
        KIND_W:  next_base = w_base_q;
        KIND_I:  next_base = i_base_q;
        default: next_base = p_base_q;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      kind  <= KIND_W;
      row   <= '0;
    end else begin
      state <= state_n;
      kind  <= kind_n;
      row   <= row_n;
    end
  end

  // Base latches, read-data hold register and registered scratchpad request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_base_q <= '0;
      i_base_q <= '0;
      p_base_q <= '0;
      hold     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (state == IDLE && start) begin
        w_base_q <= w_base;
        i_base_q <= i_base;
        p_base_q <= p_base;
      end
      if (state == FETCH && mem_ready) hold <= mem_rdata;
      mem_req <= (state_n == FETCH);
      if (state_n == FETCH && state != FETCH) mem_addr <= next_base + ADDR_W'(row_n);
    end
  end

endmodule
